// File: rtl/chess_clock_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chess_pkg: shared state encoding and player constants for the clock. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package chess_pkg;

    localparam int DEFAULT_TIME_WIDTH = 10;

    localparam logic PLAYER_WHITE = 1'b0;
    localparam logic PLAYER_BLACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_RUN_WHITE = 3'd2,
        ST_RUN_BLACK = 3'd3,
        ST_PAUSED    = 3'd4,
        ST_TIMEOUT   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/chess_clock_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chess_clock_controller_if: control pulses in, timer/status out.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface chess_clock_controller_if #(
    parameter int TIME_WIDTH = chess_pkg::DEFAULT_TIME_WIDTH
);
    logic                  div_clock;
    logic                  new_game;
    logic                  start;
    logic                  pause;
    logic                  move_done;
    logic [TIME_WIDTH-1:0] white_time;
    logic [TIME_WIDTH-1:0] black_time;
    logic                  active_black;
    logic                  running;
    logic                  timeout;
    logic                  loser_black;
    logic                  div_reset;

    modport master (
        output div_clock, new_game, start, pause, move_done,
        input  white_time, black_time, active_black, running, timeout,
               loser_black, div_reset
    );

    modport slave (
        input  div_clock, new_game, start, pause, move_done,
        output white_time, black_time, active_black, running, timeout,
               loser_black, div_reset
    );
endinterface
`default_nettype wire

// File: rtl/chess_clock_controller_player_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | player_timer: loadable seconds down-counter with saturating increment.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module player_timer #(
    parameter int TIME_WIDTH        = chess_pkg::DEFAULT_TIME_WIDTH,
    parameter int INITIAL_SECONDS   = 600,
    parameter int INCREMENT_SECONDS = 0
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  load_i,
    input  wire logic                  dec_i,
    input  wire logic                  inc_i,
    output logic      [TIME_WIDTH-1:0] time_o,
    output logic                       zero_next_o
);

    localparam logic [TIME_WIDTH:0]   C_INC  = (TIME_WIDTH+1)'(INCREMENT_SECONDS);
    localparam logic [TIME_WIDTH:0]   C_MAX  = {1'b0, {TIME_WIDTH{1'b1}}};
    localparam logic [TIME_WIDTH-1:0] C_INIT = TIME_WIDTH'(INITIAL_SECONDS);

    logic [TIME_WIDTH-1:0] count_q;
    logic [TIME_WIDTH-1:0] count_d;
    logic [TIME_WIDTH:0]   w_after_dec;
    logic [TIME_WIDTH:0]   w_after_inc;

    // Decrement first, then increment; the decrement never wraps below zero.
    assign w_after_dec = {1'b0, count_q}
                       - (((dec_i == 1'b1) && (count_q != '0)) ? (TIME_WIDTH+1)'(1) : '0);
    assign w_after_inc = w_after_dec + C_INC;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = C_INIT;
        end else if (inc_i) begin
            count_d = (w_after_inc > C_MAX) ? C_MAX[TIME_WIDTH-1:0]
                                            : w_after_inc[TIME_WIDTH-1:0];
        end else begin
            count_d = w_after_dec[TIME_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign time_o      = count_q;
    assign zero_next_o = dec_i && (count_q == TIME_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/chess_clock_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chess_clock_controller: turn FSM, second-tick steering and flag-fall. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module chess_clock_controller
    import chess_pkg::*;
#(
    parameter int TIME_WIDTH        = DEFAULT_TIME_WIDTH,
    parameter int INITIAL_SECONDS   = 600,
    parameter int INCREMENT_SECONDS = 0
) (
    input  wire logic              clock,
    input  wire logic              reset,
    chess_clock_controller_if.slave bus
);

    generate
        if ((INITIAL_SECONDS < 1) || (INITIAL_SECONDS >= (2 ** TIME_WIDTH))) begin : g_bad_initial
            $error("INITIAL_SECONDS must be in [1, 2**TIME_WIDTH - 1]");
        end
    endgenerate

    state_e state_q, state_d;
    logic   active_black_q, active_black_d;
    logic   loser_black_q, loser_black_d;
    logic   div_reset_q, div_reset_d;
    logic   running_q, timeout_q;
    logic   div_clock_q;

    logic   w_tick;
    logic   w_load;
    logic   w_dec_white, w_dec_black;
    logic   w_inc_white, w_inc_black;
    logic   w_white_zero, w_black_zero;
    logic   w_expires;

    assign w_tick      = bus.div_clock & ~div_clock_q;
    assign w_dec_white = w_tick && (state_q == ST_RUN_WHITE);
    assign w_dec_black = w_tick && (state_q == ST_RUN_BLACK);
    assign w_expires   = w_white_zero | w_black_zero;

    player_timer #(
        .TIME_WIDTH       (TIME_WIDTH),
        .INITIAL_SECONDS  (INITIAL_SECONDS),
        .INCREMENT_SECONDS(INCREMENT_SECONDS)
    ) u_white (
        .clock      (clock),
        .reset      (reset),
        .load_i     (w_load),
        .dec_i      (w_dec_white),
        .inc_i      (w_inc_white),
        .time_o     (bus.white_time),
        .zero_next_o(w_white_zero)
    );

    player_timer #(
        .TIME_WIDTH       (TIME_WIDTH),
        .INITIAL_SECONDS  (INITIAL_SECONDS),
        .INCREMENT_SECONDS(INCREMENT_SECONDS)
    ) u_black (
        .clock      (clock),
        .reset      (reset),
        .load_i     (w_load),
        .dec_i      (w_dec_black),
        .inc_i      (w_inc_black),
        .time_o     (bus.black_time),
        .zero_next_o(w_black_zero)
    );

    always_comb begin
        state_d        = state_q;
        active_black_d = active_black_q;
        loser_black_d  = loser_black_q;
        div_reset_d    = 1'b0;
        w_load         = 1'b0;
        w_inc_white    = 1'b0;
        w_inc_black    = 1'b0;
        // new_game overrides everything, including a tick arriving this cycle.
        if (bus.new_game) begin
            state_d        = ST_READY;
            w_load         = 1'b1;
            active_black_d = PLAYER_WHITE;
            loser_black_d  = 1'b0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (bus.start) begin
                        state_d        = ST_RUN_WHITE;
                        active_black_d = PLAYER_WHITE;
                        div_reset_d    = 1'b1;
                    end
                end
                ST_RUN_WHITE, ST_RUN_BLACK: begin
                    if (w_expires) begin
                        state_d       = ST_TIMEOUT;
                        loser_black_d = active_black_q;
                    end else if (bus.move_done) begin
                        w_inc_white    = (state_q == ST_RUN_WHITE);
                        w_inc_black    = (state_q == ST_RUN_BLACK);
                        state_d        = (state_q == ST_RUN_WHITE) ? ST_RUN_BLACK : ST_RUN_WHITE;
                        active_black_d = ~active_black_q;
                        div_reset_d    = 1'b1;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.pause) begin
                        state_d     = active_black_q ? ST_RUN_BLACK : ST_RUN_WHITE;
                        div_reset_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            active_black_q <= 1'b0;
            loser_black_q  <= 1'b0;
            div_reset_q    <= 1'b1;
            running_q      <= 1'b0;
            timeout_q      <= 1'b0;
            div_clock_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_black_q <= active_black_d;
            loser_black_q  <= loser_black_d;
            div_reset_q    <= div_reset_d;
            running_q      <= (state_d == ST_RUN_WHITE) || (state_d == ST_RUN_BLACK);
            timeout_q      <= (state_d == ST_TIMEOUT);
            div_clock_q    <= bus.div_clock;
        end
    end

    assign bus.active_black = active_black_q;
    assign bus.loser_black  = loser_black_q;
    assign bus.div_reset    = div_reset_q;
    assign bus.running      = running_q;
    assign bus.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_chess_clock_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chess_clock_controller: three parameterisations, vectors + model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_chess_clock_controller;

    localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSED = 3, M_TIMEOUT = 4;
    localparam int F_W = 0, F_B = 1, F_A = 2, F_R = 3, F_T = 4, F_L = 5, F_D = 6;

    logic clk = 1'b0;
    logic rst_n, div, ng, st, ps, mv;

    always #5 clk = ~clk;

    chess_clock_controller_if #(.TIME_WIDTH(10)) ifa ();
    chess_clock_controller_if #(.TIME_WIDTH(10)) ifb ();
    chess_clock_controller_if #(.TIME_WIDTH(4))  ifc ();

    assign ifa.div_clock = div; assign ifa.new_game = ng; assign ifa.start = st;
    assign ifa.pause = ps;      assign ifa.move_done = mv;
    assign ifb.div_clock = div; assign ifb.new_game = ng; assign ifb.start = st;
    assign ifb.pause = ps;      assign ifb.move_done = mv;
    assign ifc.div_clock = div; assign ifc.new_game = ng; assign ifc.start = st;
    assign ifc.pause = ps;      assign ifc.move_done = mv;

    chess_clock_controller #(.TIME_WIDTH(10), .INITIAL_SECONDS(600), .INCREMENT_SECONDS(5))
        u_a (.clock(clk), .reset(rst_n), .bus(ifa));
    chess_clock_controller #(.TIME_WIDTH(10), .INITIAL_SECONDS(2), .INCREMENT_SECONDS(2))
        u_b (.clock(clk), .reset(rst_n), .bus(ifb));
    chess_clock_controller #(.TIME_WIDTH(4), .INITIAL_SECONDS(14), .INCREMENT_SECONDS(5))
        u_c (.clock(clk), .reset(rst_n), .bus(ifc));

    int p_init[3] = '{600, 2, 14};
    int p_inc[3]  = '{5, 2, 5};
    int p_max[3]  = '{1023, 1023, 15};

    int m_mode[3], m_side[3], m_wt[3], m_bt[3], m_loser[3], m_dr[3], m_pdiv[3];
    int exp_o[3][7];
    int act[3][7];
    string fld[7];

    int checks = 0;
    int failures = 0;
    bit cmp_model = 1'b0;

    typedef struct {
        logic rst, div, ng, st, ps, mv;
        int   w, b, a, r, t, l, d;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference: mover loses a second per tick, a move banks the increment, zero flags.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_mode[k] = M_IDLE; m_side[k] = 0; m_wt[k] = 0; m_bt[k] = 0;
                m_loser[k] = 0; m_dr[k] = 1; m_pdiv[k] = 0;
            end else begin
                int  t;
                bit  tick;
                tick = div && (m_pdiv[k] == 0);
                m_pdiv[k] = int'(div);
                m_dr[k] = 0;
                if (ng) begin
                    m_mode[k] = M_READY; m_wt[k] = p_init[k]; m_bt[k] = p_init[k];
                    m_side[k] = 0; m_loser[k] = 0;
                end else if (m_mode[k] == M_READY) begin
                    if (st) begin m_mode[k] = M_RUN; m_side[k] = 0; m_dr[k] = 1; end
                end else if (m_mode[k] == M_RUN) begin
                    t = (m_side[k] != 0) ? m_bt[k] : m_wt[k];
                    if (tick && t > 0) t = t - 1;
                    if (tick && t == 0) begin
                        m_mode[k] = M_TIMEOUT; m_loser[k] = m_side[k];
                        if (m_side[k] != 0) m_bt[k] = t; else m_wt[k] = t;
                    end else if (mv) begin
                        t = t + p_inc[k];
                        if (t > p_max[k]) t = p_max[k];
                        if (m_side[k] != 0) m_bt[k] = t; else m_wt[k] = t;
                        m_side[k] = 1 - m_side[k];
                        m_dr[k] = 1;
                    end else begin
                        if (m_side[k] != 0) m_bt[k] = t; else m_wt[k] = t;
                        if (ps) m_mode[k] = M_PAUSED;
                    end
                end else if (m_mode[k] == M_PAUSED && ps) begin
                    m_mode[k] = M_RUN; m_dr[k] = 1;
                end
            end
            exp_o[k][F_W] = m_wt[k];
            exp_o[k][F_B] = m_bt[k];
            exp_o[k][F_A] = m_side[k];
            exp_o[k][F_R] = (m_mode[k] == M_RUN) ? 1 : 0;
            exp_o[k][F_T] = (m_mode[k] == M_TIMEOUT) ? 1 : 0;
            exp_o[k][F_L] = m_loser[k];
            exp_o[k][F_D] = m_dr[k];
        end
    endtask

    task automatic read_all();
        act[0][F_W] = int'(ifa.white_time); act[0][F_B] = int'(ifa.black_time);
        act[0][F_A] = int'(ifa.active_black); act[0][F_R] = int'(ifa.running);
        act[0][F_T] = int'(ifa.timeout); act[0][F_L] = int'(ifa.loser_black);
        act[0][F_D] = int'(ifa.div_reset);
        act[1][F_W] = int'(ifb.white_time); act[1][F_B] = int'(ifb.black_time);
        act[1][F_A] = int'(ifb.active_black); act[1][F_R] = int'(ifb.running);
        act[1][F_T] = int'(ifb.timeout); act[1][F_L] = int'(ifb.loser_black);
        act[1][F_D] = int'(ifb.div_reset);
        act[2][F_W] = int'(ifc.white_time); act[2][F_B] = int'(ifc.black_time);
        act[2][F_A] = int'(ifc.active_black); act[2][F_R] = int'(ifc.running);
        act[2][F_T] = int'(ifc.timeout); act[2][F_L] = int'(ifc.loser_black);
        act[2][F_D] = int'(ifc.div_reset);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        read_all();
        if (cmp_model) begin
            for (int k = 0; k < 3; k++)
                for (int f = 0; f < 7; f++)
                    check($sformatf("dut%0d_%s", k, fld[f]), act[k][f], exp_o[k][f]);
        end
    endtask

    task automatic chk(input string name, input int k, input int f, input int expv);
        check($sformatf("%s_dut%0d_%s", name, k, fld[f]), act[k][f], expv);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: ng = 1'b1;
            1: st = 1'b1;
            2: ps = 1'b1;
            default: mv = 1'b1;
        endcase
        step();
        ng = 1'b0; st = 1'b0; ps = 1'b0; mv = 1'b0;
    endtask

    task automatic tick();
        div = 1'b1; step();
        div = 1'b0; step();
    endtask

    initial begin
        fld = '{"white_time", "black_time", "active_black", "running",
                "timeout", "loser_black", "div_reset"};
        rst_n = 1'b0; div = 1'b0; ng = 1'b0; st = 1'b0; ps = 1'b0; mv = 1'b0;

        // rst div ng st ps mv | white black act run to loser divrst  (600 s, +5)
        vecs[0]  = '{0,0,0,0,0,0,   0,   0, 0, 0, 0, 0, 1};
        vecs[1]  = '{1,0,1,0,0,0, 600, 600, 0, 0, 0, 0, 0};
        vecs[2]  = '{1,0,0,1,0,0, 600, 600, 0, 1, 0, 0, 1};
        vecs[3]  = '{1,1,0,0,0,0, 599, 600, 0, 1, 0, 0, 0};
        vecs[4]  = '{1,0,0,0,0,0, 599, 600, 0, 1, 0, 0, 0};
        vecs[5]  = '{1,1,0,0,0,0, 598, 600, 0, 1, 0, 0, 0};
        vecs[6]  = '{1,1,0,0,0,0, 598, 600, 0, 1, 0, 0, 0};
        vecs[7]  = '{1,0,0,0,0,0, 598, 600, 0, 1, 0, 0, 0};
        vecs[8]  = '{1,1,0,0,0,0, 597, 600, 0, 1, 0, 0, 0};
        vecs[9]  = '{1,0,0,0,0,1, 602, 600, 1, 1, 0, 0, 1};
        vecs[10] = '{1,1,0,0,0,0, 602, 599, 1, 1, 0, 0, 0};
        vecs[11] = '{1,0,0,0,0,0, 602, 599, 1, 1, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            rst_n = vecs[i].rst; div = vecs[i].div; ng = vecs[i].ng;
            st = vecs[i].st; ps = vecs[i].ps; mv = vecs[i].mv;
            step();
            check($sformatf("vec%0d_white", i), act[0][F_W], vecs[i].w);
            check($sformatf("vec%0d_black", i), act[0][F_B], vecs[i].b);
            check($sformatf("vec%0d_active", i), act[0][F_A], vecs[i].a);
            check($sformatf("vec%0d_running", i), act[0][F_R], vecs[i].r);
            check($sformatf("vec%0d_timeout", i), act[0][F_T], vecs[i].t);
            check($sformatf("vec%0d_loser", i), act[0][F_L], vecs[i].l);
            check($sformatf("vec%0d_divrst", i), act[0][F_D], vecs[i].d);
        end
        mv = 1'b0;

        // Pause while black is to move: black frozen, resume restarts the divider.
        pulse(2);
        chk("pause_enter", 0, F_R, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("paused_hold", 0, F_B, 599);
        chk("paused_hold", 0, F_D, 0);
        pulse(2);
        chk("resume", 0, F_R, 1);
        chk("resume", 0, F_A, 1);
        chk("resume", 0, F_D, 1);
        tick();
        chk("resume_tick", 0, F_B, 598);
        chk("resume_tick", 0, F_W, 602);

        // Flag-fall on the 2 s game, then the terminal state ignores ticks and moves.
        pulse(0); pulse(1);
        tick();
        chk("flag_1s", 1, F_W, 1);
        tick();
        chk("flag", 1, F_W, 0);
        chk("flag", 1, F_T, 1);
        chk("flag", 1, F_L, 0);
        chk("flag", 1, F_R, 0);
        tick(); tick(); pulse(3);
        chk("flag_hold", 1, F_W, 0);
        chk("flag_hold", 1, F_B, 2);
        chk("flag_hold", 1, F_T, 1);
        chk("flag_hold", 1, F_A, 0);

        // Tick and move in the same cycle with one second left: timeout wins.
        pulse(0); pulse(1);
        tick();
        div = 1'b1; mv = 1'b1; step();
        mv = 1'b0; div = 1'b0; step();
        chk("tickmove_last", 1, F_T, 1);
        chk("tickmove_last", 1, F_L, 0);
        chk("tickmove_last", 1, F_A, 0);
        chk("tickmove_last", 1, F_W, 0);

        // Same collision with 10 s left: 10 - 1 + 2 = 11 and the turn passes.
        pulse(0); pulse(1);
        for (int i = 0; i < 8; i++) pulse(3);
        chk("build10", 1, F_W, 10);
        div = 1'b1; mv = 1'b1; step();
        mv = 1'b0;
        chk("tickmove_10", 1, F_W, 11);
        chk("tickmove_10", 1, F_A, 1);
        chk("tickmove_10", 1, F_T, 0);
        chk("tickmove_10", 1, F_D, 1);
        div = 1'b0; step();

        // Reset while black is running, then a saturating increment on the 4-bit clock.
        pulse(0); pulse(1); pulse(3);
        chk("pre_reset", 0, F_A, 1);
        rst_n = 1'b0; step();
        for (int f = 0; f < 7; f++) chk("mid_reset", 0, f, (f == F_D) ? 1 : 0);
        rst_n = 1'b1;
        pulse(0); pulse(1); pulse(3);
        chk("saturate", 2, F_W, 15);
        chk("saturate", 2, F_A, 1);

        // Randomised traffic, every output of every instance against the model.
        cmp_model = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(399) != 0);
            ng    = ($urandom_range(99) == 0);
            st    = ($urandom_range(9) == 0);
            ps    = ($urandom_range(24) == 0);
            mv    = ($urandom_range(11) == 0);
            if ($urandom_range(2) == 0) div = ~div;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chess_clock_controller.md
Name: chess_clock_controller

Overview:
- Sequences the game's two countdown timers (white, black) from the divided 1 Hz clock.
- Turns the divider's toggling output into one-cycle second ticks and steers each tick to the active player.
- Switches turns on committed moves and detects flag-fall (timeout).
- Restarts the divider phase on every turn switch so each turn starts on a whole-second boundary. Sits between the clock divider and the game FSM / display.

Parameters:
- TIME_WIDTH, 10, width of each player's seconds counter.
- INITIAL_SECONDS, 600, value loaded into both counters on new game.
- INCREMENT_SECONDS, 0, seconds added to the mover's counter on each move (Fischer increment).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- div_clock  input  1  toggling output of the clock divider (same clock domain, registered there).
- new_game  input  1  one-cycle pulse; loads both timers, enters READY.
- start  input  1  one-cycle pulse; READY -> RUN_WHITE.
- pause  input  1  one-cycle pulse; toggles RUN_x <-> PAUSED.
- move_done  input  1  one-cycle pulse from game FSM; active player committed a move.
- white_time  output  TIME_WIDTH  white remaining seconds.
- black_time  output  TIME_WIDTH  black remaining seconds.
- active_black  output  1  0 = white to move, 1 = black to move.
- running  output  1  high in RUN_WHITE / RUN_BLACK.
- timeout  output  1  high in TIMEOUT.
- loser_black  output  1  valid when timeout = 1; 1 = black flagged.
- div_reset  output  1  active-high one-cycle pulse to the divider's reset.

Behaviour:
- Reset (reset = 0 at clock edge): state IDLE; white_time = black_time = 0; active_black = 0; running = timeout = loser_black = 0; div_reset = 1 (held while in reset); edge-detect register cleared to 0.
- Tick generation: div_clock_q registered every cycle; tick = div_clock & ~div_clock_q, which is one cycle after the rising edge of div_clock. A tick counts only in RUN_x states. Ticks in other states are dropped, not queued.
- States:
  - IDLE: new_game -> READY.
  - READY: timers = INITIAL_SECONDS; start -> RUN_WHITE with div_reset pulse.
  - RUN_WHITE / RUN_BLACK:
    - tick decrements the active counter.
    - move_done adds INCREMENT_SECONDS to the mover, flips to the other RUN state, and pulses div_reset.
    - pause -> PAUSED, remembering the side to move.
  - PAUSED: pause -> back to the remembered RUN state with a div_reset pulse; move_done ignored.
  - TIMEOUT: terminal until new_game (-> READY) or reset.
- new_game in any non-IDLE state -> READY, timers reloaded, and a pending tick is discarded.
- Timeout: if the active counter is 1 and a tick arrives, the counter becomes 0 and the next state is TIMEOUT, with loser_black = active_black. Counters never go below 0.
- Same-cycle tick and move_done in RUN_x:
  - The decrement applies to the mover first, then the increment.
  - If the decrement reaches 0, TIMEOUT wins and the move is ignored.
- Same-cycle pause and move_done: move_done takes priority, pause is ignored.
- Same-cycle new_game with any other input: new_game wins.
- Increment arithmetic: computed TIME_WIDTH+1 wide, saturates at 2^TIME_WIDTH-1.
- INITIAL_SECONDS must be >= 1 and < 2^TIME_WIDTH; this is checked by an elaboration-time assertion.
- Latency:
  - Outputs are registered.
  - A counter change is visible the cycle after the tick.
  - active_black flips the cycle after move_done.
  - div_reset is high exactly one cycle, in the cycle after the triggering pulse.

Decomposition:
- Shared package chess_pkg:
  - state enum (IDLE, READY, RUN_WHITE, RUN_BLACK, PAUSED, TIMEOUT);
  - PLAYER_WHITE / PLAYER_BLACK constants;
  - default TIME_WIDTH.
- One sub-module: player_timer, instantiated twice. It holds a loadable down-counter with saturating add-increment and a zero flag.
- The FSM and tick edge detect stay in the top module.

Test Plan:
- Reset, new_game, start, then 3 div_clock rising edges -> white_time 600 -> 597, black_time 600, div_reset pulsed once after start.
- RUN_WHITE at 597, move_done with INCREMENT_SECONDS = 5 -> white_time 602, active_black = 1, div_reset high 1 cycle; a subsequent tick decrements black only.
- INITIAL_SECONDS = 2, start, 2 ticks -> white_time 0, timeout = 1, loser_black = 0, running = 0; further ticks and move_done leave all outputs unchanged.
- pause in RUN_BLACK, 4 ticks, pause -> black_time unchanged while paused, resumes in RUN_BLACK, div_reset pulses on resume.
- Tick and move_done in the same cycle with white_time = 1 -> TIMEOUT, loser_black = 0, active_black stays 0. Repeat with white_time = 10 and INCREMENT_SECONDS = 2 -> 11, turn switches.
- reset = 0 mid-RUN_BLACK -> next cycle IDLE, all outputs at reset values. TIME_WIDTH = 4, INITIAL_SECONDS = 14, INCREMENT_SECONDS = 5, move -> mover's counter saturates at 15.
